// File: rtl/gp_regfile_pkg.sv
// Shared constants, busy-vector type and flattened-port slicing helper for the register file.
// Pure definitions: no state, no latency, no backpressure.
package gp_regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  typedef logic [NREGS_DEF-1:0] busy_vec_t;

  // Start bit of lane k in a flattened bus of w-bit lanes.
  function automatic int idx_slice(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy bits: issue sets, writeback clears, flush wipes; raw lookups per read port.
// Lookups and iss_ready are combinational; updates land at the edge; iss_ready stalls issue on WAW.
module reg_scoreboard
  import gp_regfile_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int NREAD = 2,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREAD*AW-1:0] lk_idx,
  output logic [NREAD-1:0]    lk_busy,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_idx,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd,
  output logic                iss_ready,
  input  logic                flush
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // A writeback landing this cycle frees the slot for a new owner.
  assign iss_ready = (iss_rd == '0) || !busy_q[iss_rd] ||
                     (wr_en && (wr_idx == iss_rd));

  always_comb begin
    busy_d = busy_q;
    if (wr_en && (wr_idx != '0)) begin
      busy_d[wr_idx] = 1'b0;
    end
    if (iss_valid && iss_ready && (iss_rd != '0)) begin
      busy_d[iss_rd] = 1'b1;
    end
    if (flush) begin
      busy_d = '0;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_lookup
    assign lk_busy[k] = busy_q[lk_idx[idx_slice(k, AW) +: AW]];
  end

endmodule

// File: rtl/gp_regfile_sb.sv
// Integer register file + PC with NREAD bypassed read ports, debug port and busy scoreboard.
// Reads/hazards are 0-cycle combinational, writes commit at the edge; iss_ready holds off issue.
module gp_regfile_sb
  import gp_regfile_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter int              NREGS    = NREGS_DEF,
  parameter int              NREAD    = 2,
  parameter int              BYPASS   = 1,
  parameter logic [XLEN-1:0] PC_RESET = '0,
  localparam int             AW       = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREAD*AW-1:0]   rd_idx,
  output logic [NREAD*XLEN-1:0] rd_data,
  output logic [NREAD-1:0]      rd_busy,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_idx,
  input  logic [XLEN-1:0]       wr_data,
  input  logic                  iss_valid,
  input  logic [AW-1:0]         iss_rd,
  output logic                  iss_ready,
  input  logic                  flush,
  input  logic                  pc_we,
  input  logic [XLEN-1:0]       pc_wdata,
  output logic [XLEN-1:0]       pc_rdata,
  input  logic [AW-1:0]         dbg_idx,
  output logic [XLEN-1:0]       dbg_data
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [XLEN-1:0]  pc_q;
  logic [XLEN-1:0]  pc_d;
  logic [NREAD-1:0] sb_busy;

  always_comb begin
    regs_d = regs_q;
    if (wr_en && (wr_idx != '0)) begin
      regs_d[wr_idx] = wr_data;
    end
  end

  always_comb begin
    pc_d = pc_q;
    if (pc_we) begin
      pc_d = pc_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      foreach (regs_q[i]) begin
        regs_q[i] <= '0;
      end
      pc_q <= PC_RESET;
    end else begin
      regs_q <= regs_d;
      pc_q   <= pc_d;
    end
  end

  reg_scoreboard #(
    .NREGS (NREGS),
    .NREAD (NREAD),
    .AW    (AW)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .lk_idx    (rd_idx),
    .lk_busy   (sb_busy),
    .wr_en     (wr_en),
    .wr_idx    (wr_idx),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .iss_ready (iss_ready),
    .flush     (flush)
  );

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [AW-1:0] idx;
    logic          hit;

    assign idx = rd_idx[idx_slice(k, AW) +: AW];

    if (BYPASS != 0) begin : g_byp
      assign hit = wr_en && (wr_idx == idx);
    end else begin : g_nobyp
      assign hit = 1'b0;
    end

    // A forwarded write has already resolved the hazard, so it also masks busy.
    assign rd_data[idx_slice(k, XLEN) +: XLEN] = (idx == '0) ? '0 :
                                                 hit          ? wr_data :
                                                                regs_q[idx];
    assign rd_busy[k] = (idx != '0) && !hit && sb_busy[k];
  end

  assign pc_rdata = pc_q;
  assign dbg_data = (dbg_idx == '0) ? '0 : regs_q[dbg_idx];

endmodule

// File: tb/tb_gp_regfile_sb.sv
// Scoreboard bench: two DUTs (bypass on/off) against a reference model of the register file.
module tb_gp_regfile_sb;
  import gp_regfile_pkg::*;

  localparam int          AW  = 5;
  localparam logic [31:0] PCR = 32'h0000_0080;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rd_idx;
  logic        wr_en;
  logic [4:0]  wr_idx;
  logic [31:0] wr_data;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        flush;
  logic        pc_we;
  logic [31:0] pc_wdata;
  logic [4:0]  dbg_idx;

  logic [63:0] rd_data_b, rd_data_n;
  logic [1:0]  rd_busy_b, rd_busy_n;
  logic        iss_ready_b, iss_ready_n;
  logic [31:0] pc_rdata_b, pc_rdata_n;
  logic [31:0] dbg_data_b, dbg_data_n;

  always #5 clk = ~clk;

  gp_regfile_sb #(.XLEN(32), .NREGS(32), .NREAD(2), .BYPASS(1), .PC_RESET(PCR)) u_byp (
    .clk(clk), .rst(rst), .rd_idx(rd_idx), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .iss_valid(iss_valid),
    .iss_rd(iss_rd), .iss_ready(iss_ready_b), .flush(flush), .pc_we(pc_we),
    .pc_wdata(pc_wdata), .pc_rdata(pc_rdata_b), .dbg_idx(dbg_idx), .dbg_data(dbg_data_b)
  );

  gp_regfile_sb #(.XLEN(32), .NREGS(32), .NREAD(2), .BYPASS(0), .PC_RESET(PCR)) u_nobyp (
    .clk(clk), .rst(rst), .rd_idx(rd_idx), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .iss_valid(iss_valid),
    .iss_rd(iss_rd), .iss_ready(iss_ready_n), .flush(flush), .pc_we(pc_we),
    .pc_wdata(pc_wdata), .pc_rdata(pc_rdata_n), .dbg_idx(dbg_idx), .dbg_data(dbg_data_n)
  );

  logic [31:0] m_regs [32];
  busy_vec_t   m_busy;
  logic [31:0] m_pc;

  logic [31:0] exp_q [$];
  int          sel_q [$];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic string sel_name(input int s);
    case (s)
      0:  return "byp_rd_data0";
      1:  return "byp_rd_data1";
      2:  return "byp_rd_busy0";
      3:  return "byp_rd_busy1";
      4:  return "byp_iss_ready";
      5:  return "byp_pc_rdata";
      6:  return "byp_dbg_data";
      7:  return "nob_rd_data0";
      8:  return "nob_rd_data1";
      9:  return "nob_rd_busy0";
      10: return "nob_rd_busy1";
      11: return "nob_iss_ready";
      12: return "nob_pc_rdata";
      default: return "nob_dbg_data";
    endcase
  endfunction

  function automatic logic [31:0] observe(input int s);
    case (s)
      0:  return rd_data_b[31:0];
      1:  return rd_data_b[63:32];
      2:  return {31'd0, rd_busy_b[0]};
      3:  return {31'd0, rd_busy_b[1]};
      4:  return {31'd0, iss_ready_b};
      5:  return pc_rdata_b;
      6:  return dbg_data_b;
      7:  return rd_data_n[31:0];
      8:  return rd_data_n[63:32];
      9:  return {31'd0, rd_busy_n[0]};
      10: return {31'd0, rd_busy_n[1]};
      11: return {31'd0, iss_ready_n};
      12: return pc_rdata_n;
      default: return dbg_data_n;
    endcase
  endfunction

  function automatic logic [31:0] m_rd(input logic [4:0] idx, input bit byp);
    if (idx == 5'd0) return 32'd0;
    if (byp && wr_en && (wr_idx == idx)) return wr_data;
    return m_regs[idx];
  endfunction

  function automatic logic [31:0] m_rbusy(input logic [4:0] idx, input bit byp);
    if (idx == 5'd0) return 32'd0;
    if (byp && wr_en && (wr_idx == idx)) return 32'd0;
    return {31'd0, m_busy[idx]};
  endfunction

  function automatic logic m_ready();
    return (iss_rd == 5'd0) || !m_busy[iss_rd] || (wr_en && (wr_idx == iss_rd));
  endfunction

  task automatic push(input int s, input logic [31:0] v);
    sel_q.push_back(s);
    exp_q.push_back(v);
  endtask

  task automatic model_update();
    logic rdy;
    if (rst) begin
      foreach (m_regs[i]) m_regs[i] = 32'd0;
      m_busy = '0;
      m_pc   = PCR;
    end else begin
      rdy = m_ready();
      if (wr_en && (wr_idx != 5'd0)) begin
        m_regs[wr_idx] = wr_data;
        m_busy[wr_idx] = 1'b0;
      end
      if (iss_valid && rdy && (iss_rd != 5'd0)) m_busy[iss_rd] = 1'b1;
      if (flush) m_busy = '0;
      if (pc_we) m_pc = pc_wdata;
    end
  endtask

  // Called at posedge+1 with inputs already driven for this cycle.
  task automatic cycle();
    logic [4:0]  i0, i1;
    logic [31:0] dbg_exp;
    int          s;
    logic [31:0] e;
    i0 = rd_idx[4:0];
    i1 = rd_idx[9:5];
    dbg_exp = (dbg_idx == 5'd0) ? 32'd0 : m_regs[dbg_idx];
    push(0, m_rd(i0, 1'b1));    push(1, m_rd(i1, 1'b1));
    push(2, m_rbusy(i0, 1'b1)); push(3, m_rbusy(i1, 1'b1));
    push(4, {31'd0, m_ready()}); push(5, m_pc); push(6, dbg_exp);
    push(7, m_rd(i0, 1'b0));    push(8, m_rd(i1, 1'b0));
    push(9, m_rbusy(i0, 1'b0)); push(10, m_rbusy(i1, 1'b0));
    push(11, {31'd0, m_ready()}); push(12, m_pc); push(13, dbg_exp);
    #2;
    while (sel_q.size() > 0) begin
      s = sel_q.pop_front();
      e = exp_q.pop_front();
      check_eq(sel_name(s), observe(s), e);
    end
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    rst = 0; wr_en = 0; wr_idx = 0; wr_data = 0; iss_valid = 0; iss_rd = 0;
    flush = 0; pc_we = 0; pc_wdata = 0;
  endtask

  task automatic set_rd(input logic [4:0] a, input logic [4:0] b);
    rd_idx = {b, a};
  endtask

  task automatic do_wr(input logic [4:0] idx, input logic [31:0] d);
    wr_en = 1; wr_idx = idx; wr_data = d;
  endtask

  task automatic do_iss(input logic [4:0] idx);
    iss_valid = 1; iss_rd = idx;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(); set_rd(5, 0); dbg_idx = 5;
    rst = 1; do_wr(5, 32'hDEAD);
    @(posedge clk); model_update(); #1;
    cycle();
    idle(); cycle();

    // write with same-cycle forwarding, then stored read
    set_rd(3, 5); dbg_idx = 3; do_wr(3, 32'h1234); cycle();
    idle(); cycle();

    // x0 is hard-wired zero and never reservable
    set_rd(0, 0); dbg_idx = 0; do_wr(0, 32'hFFFF_FFFF); cycle();
    idle(); do_iss(0); cycle();
    idle(); cycle();

    // RAW/WAW tracking on x7
    do_iss(7); cycle();
    idle(); set_rd(3, 7); do_iss(7); cycle();
    idle(); do_wr(7, 32'h42); do_iss(7); dbg_idx = 7; cycle();
    idle(); cycle();
    do_wr(7, 32'h43); cycle();
    idle(); cycle();

    // flush beats a concurrent issue, writeback still commits
    do_iss(2); cycle();
    do_iss(9); cycle();
    do_iss(31); set_rd(9, 2); cycle();
    idle(); set_rd(9, 31); cycle();
    do_iss(4); flush = 1; do_wr(9, 32'h5); dbg_idx = 9; cycle();
    idle(); set_rd(9, 4); cycle();
    set_rd(2, 31); cycle();

    // PC load, hold, reset
    pc_we = 1; pc_wdata = 32'h0000_0100; cycle();
    idle(); cycle(); cycle(); cycle();
    rst = 1; cycle();
    idle(); set_rd(3, 9); cycle();

    for (int n = 0; n < 80; n++) begin
      rst       = ($urandom_range(0, 24) == 0);
      wr_en     = $urandom_range(0, 1);
      wr_idx    = 5'($urandom_range(0, 7));
      wr_data   = $urandom;
      iss_valid = $urandom_range(0, 1);
      iss_rd    = 5'($urandom_range(0, 7));
      flush     = ($urandom_range(0, 9) == 0);
      pc_we     = $urandom_range(0, 1);
      pc_wdata  = $urandom;
      dbg_idx   = 5'($urandom_range(0, 31));
      set_rd(5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
